// File: rtl/pwm_ramp_scheduler_if.sv
// pwm_ramp_scheduler_if: ramp command handshake between requester and scheduler
interface pwm_ramp_scheduler_if #(
  parameter int PWM_WIDTH = 10
) ();
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [PWM_WIDTH-1:0] cmd_target;
  logic [PWM_WIDTH-1:0] cmd_step;
  modport master (output cmd_valid, cmd_target, cmd_step, input cmd_ready);
  modport slave (input cmd_valid, cmd_target, cmd_step, output cmd_ready);
endinterface

// File: rtl/pwm_ramp_scheduler.sv
// pwm_ramp_scheduler: period sync generation and per-period duty ramping for pwm_generator
module pwm_ramp_scheduler #(
  parameter int PWM_WIDTH    = 10,
  parameter int TLSB_WIDTH   = 12,
  parameter int DEFAULT_TLSB = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [TLSB_WIDTH-1:0] cfg_t_lsb,
  pwm_ramp_scheduler_if.slave   cmd,
  output logic                  sync_signal,
  output logic [PWM_WIDTH-1:0]  pwm_value,
  output logic [TLSB_WIDTH-1:0] t_lsb,
  output logic                  busy,
  output logic                  ramp_done
);
  localparam logic [1:0] OFF  = 2'd0;
  localparam logic [1:0] IDLE = 2'd1;
  localparam logic [1:0] RAMP = 2'd2;
  logic [1:0]            state;
  logic [TLSB_WIDTH-1:0] lsb_cnt, tl_eff;
  logic [PWM_WIDTH-1:0]  slot_cnt, target, step, diff, stepped;
  logic                  tick, period_end, up, arrive;
  always_comb begin
    tl_eff     = t_lsb == '0 ? TLSB_WIDTH'(1) : t_lsb;
    tick       = lsb_cnt == tl_eff - TLSB_WIDTH'(1);
    period_end = tick && &slot_cnt;
    up         = target > pwm_value;
    diff       = up ? target - pwm_value : pwm_value - target;
    arrive     = step == '0 || diff <= step;
    stepped    = up ? pwm_value + step : pwm_value - step;
  end
  // enable low wins over everything but reset; t_lsb is deliberately kept on entry to OFF
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= OFF;
      sync_signal   <= 1'b1;
      pwm_value     <= '0;
      t_lsb         <= TLSB_WIDTH'(DEFAULT_TLSB);
      cmd.cmd_ready <= 1'b0;
      busy          <= 1'b0;
      ramp_done     <= 1'b0;
      lsb_cnt       <= '0;
      slot_cnt      <= '0;
      target        <= '0;
      step          <= '0;
    end else if (!enable) begin
      state         <= OFF;
      sync_signal   <= 1'b1;
      pwm_value     <= '0;
      cmd.cmd_ready <= 1'b0;
      busy          <= 1'b0;
      ramp_done     <= 1'b0;
      lsb_cnt       <= '0;
      slot_cnt      <= '0;
    end else if (state == OFF) begin
      state         <= IDLE;
      sync_signal   <= 1'b0;
      cmd.cmd_ready <= 1'b1;
      ramp_done     <= 1'b0;
    end else begin
      sync_signal <= period_end;
      ramp_done   <= 1'b0;
      lsb_cnt     <= tick ? '0 : lsb_cnt + TLSB_WIDTH'(1);
      if (tick) slot_cnt <= slot_cnt + PWM_WIDTH'(1);
      if (period_end) t_lsb <= cfg_t_lsb;
      if (state == IDLE && cmd.cmd_valid && cmd.cmd_ready) begin
        target        <= cmd.cmd_target;
        step          <= cmd.cmd_step;
        cmd.cmd_ready <= 1'b0;
        busy          <= 1'b1;
        state         <= RAMP;
      end
      if (state == RAMP && period_end) begin
        pwm_value <= arrive ? target : stepped;
        if (arrive) begin
          ramp_done     <= 1'b1;
          busy          <= 1'b0;
          cmd.cmd_ready <= 1'b1;
          state         <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_pwm_ramp_scheduler.sv
// tb_pwm_ramp_scheduler: directed checks of period timing, ramping, enable and reset behaviour
module tb_pwm_ramp_scheduler;
  localparam int PW = 10;
  localparam int TW = 12;
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [TW-1:0] cfg_t_lsb = TW'(2);
  logic          sync_signal, busy, ramp_done;
  logic [PW-1:0] pwm_value;
  logic [TW-1:0] t_lsb;
  int            checks = 0;
  int            errors = 0;
  pwm_ramp_scheduler_if #(.PWM_WIDTH(PW)) cmd ();
  pwm_ramp_scheduler #(.PWM_WIDTH(PW), .TLSB_WIDTH(TW), .DEFAULT_TLSB(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg_t_lsb(cfg_t_lsb), .cmd(cmd),
    .sync_signal(sync_signal), .pwm_value(pwm_value), .t_lsb(t_lsb),
    .busy(busy), .ramp_done(ramp_done)
  );
  always #5 clk = ~clk;

  // {sync, pwm_value, t_lsb, cmd_ready, busy, ramp_done}
  function automatic logic [25:0] snap();
    return {sync_signal, pwm_value, t_lsb, cmd.cmd_ready, busy, ramp_done};
  endfunction

  task automatic wait_sync(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sync_signal && n < 6000);
  endtask

  task automatic send(input int tgt, input int stp);
    cmd.cmd_valid  = 1'b1;
    cmd.cmd_target = PW'(tgt);
    cmd.cmd_step   = PW'(stp);
    @(negedge clk);
    cmd.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1; enable = 1'b1; cfg_t_lsb = TW'(2);
    cmd.cmd_valid = 1'b0; cmd.cmd_target = '0; cmd.cmd_step = '0;
    repeat (5) @(negedge clk);
    checks++; if (snap() !== {1'b1, 10'd0, 12'd2, 3'b000}) begin errors++; $display("FAIL reset_state got %h want %h", snap(), {1'b1, 10'd0, 12'd2, 3'b000}); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (snap() !== {1'b0, 10'd0, 12'd2, 3'b100}) begin errors++; $display("FAIL first_idle got %h want %h", snap(), {1'b0, 10'd0, 12'd2, 3'b100}); end
    wait_sync(n);
    checks++; if (n !== 2048) begin errors++; $display("FAIL first_period got %0d want 2048", n); end
    checks++; if (snap() !== {1'b1, 10'd0, 12'd2, 3'b100}) begin errors++; $display("FAIL first_pulse got %h want %h", snap(), {1'b1, 10'd0, 12'd2, 3'b100}); end
    @(negedge clk);
    checks++; if (sync_signal !== 1'b0) begin errors++; $display("FAIL pulse_width got %b want 0", sync_signal); end
    wait_sync(n);
    checks++; if (n !== 2047) begin errors++; $display("FAIL second_period got %0d want 2047", n); end
  endtask

  task automatic test_ramp_up();
    int n;
    cmd.cmd_valid = 1'b1; cmd.cmd_target = PW'(500); cmd.cmd_step = PW'(100);
    @(negedge clk);
    cmd.cmd_valid = 1'b0;
    checks++; if ({cmd.cmd_ready, busy} !== 2'b01) begin errors++; $display("FAIL accept got %b want 01", {cmd.cmd_ready, busy}); end
    for (int k = 1; k <= 5; k++) begin
      wait_sync(n);
      if (k > 1) begin
        checks++; if (n !== 2048) begin errors++; $display("FAIL up_period%0d got %0d want 2048", k, n); end
      end
      checks++; if (snap() !== {1'b1, PW'(k * 100), 12'd2, (k == 5) ? 3'b101 : 3'b010}) begin errors++; $display("FAIL up_step%0d got %h want %h", k, snap(), {1'b1, PW'(k * 100), 12'd2, (k == 5) ? 3'b101 : 3'b010}); end
    end
    @(negedge clk);
    checks++; if ({cmd.cmd_ready, busy, ramp_done} !== 3'b100) begin errors++; $display("FAIL done_width got %b want 100", {cmd.cmd_ready, busy, ramp_done}); end
  endtask

  task automatic test_ramp_down_and_jump();
    int n;
    send(130, 200);
    wait_sync(n);
    checks++; if (snap() !== {1'b1, 10'd300, 12'd2, 3'b010}) begin errors++; $display("FAIL down_step1 got %h want %h", snap(), {1'b1, 10'd300, 12'd2, 3'b010}); end
    wait_sync(n);
    checks++; if (snap() !== {1'b1, 10'd130, 12'd2, 3'b101}) begin errors++; $display("FAIL down_step2 got %h want %h", snap(), {1'b1, 10'd130, 12'd2, 3'b101}); end
    send(1023, 0);
    wait_sync(n);
    checks++; if (snap() !== {1'b1, 10'd1023, 12'd2, 3'b101}) begin errors++; $display("FAIL jump got %h want %h", snap(), {1'b1, 10'd1023, 12'd2, 3'b101}); end
  endtask

  task automatic test_tlsb_change();
    int n;
    repeat (100) @(negedge clk);
    cfg_t_lsb = TW'(0);
    wait_sync(n);
    checks++; if (n !== 1948) begin errors++; $display("FAIL tlsb_old_period got %0d want 1948", n); end
    checks++; if (snap() !== {1'b1, 10'd1023, 12'd0, 3'b100}) begin errors++; $display("FAIL tlsb_update got %h want %h", snap(), {1'b1, 10'd1023, 12'd0, 3'b100}); end
    wait_sync(n);
    checks++; if (n !== 1024) begin errors++; $display("FAIL tlsb0_period got %0d want 1024", n); end
    cfg_t_lsb = TW'(2);
    wait_sync(n);
    checks++; if ({n, t_lsb} !== {32'd1024, 12'd2}) begin errors++; $display("FAIL tlsb_restore got %0d/%0d want 1024/2", n, t_lsb); end
    wait_sync(n);
    checks++; if (n !== 2048) begin errors++; $display("FAIL tlsb2_period got %0d want 2048", n); end
  endtask

  task automatic test_enable_drop();
    int n;
    int seen;
    send(0, 0);
    wait_sync(n);
    checks++; if (snap() !== {1'b1, 10'd0, 12'd2, 3'b101}) begin errors++; $display("FAIL to_zero got %h want %h", snap(), {1'b1, 10'd0, 12'd2, 3'b101}); end
    send(500, 100);
    wait_sync(n);
    wait_sync(n);
    checks++; if (snap() !== {1'b1, 10'd200, 12'd2, 3'b010}) begin errors++; $display("FAIL pre_disable got %h want %h", snap(), {1'b1, 10'd200, 12'd2, 3'b010}); end
    repeat (50) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    checks++; if (snap() !== {1'b1, 10'd0, 12'd2, 3'b000}) begin errors++; $display("FAIL disable got %h want %h", snap(), {1'b1, 10'd0, 12'd2, 3'b000}); end
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (ramp_done || !sync_signal || busy) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL off_hold got %0d bad cycles want 0", seen); end
    enable = 1'b1;
    @(negedge clk);
    checks++; if (snap() !== {1'b0, 10'd0, 12'd2, 3'b100}) begin errors++; $display("FAIL reenable got %h want %h", snap(), {1'b0, 10'd0, 12'd2, 3'b100}); end
    wait_sync(n);
    checks++; if (n !== 2048) begin errors++; $display("FAIL restart_period got %0d want 2048", n); end
  endtask

  task automatic test_reset_mid_ramp();
    int n;
    cfg_t_lsb = TW'(3);
    send(500, 100);
    wait_sync(n);
    checks++; if (snap() !== {1'b1, 10'd100, 12'd3, 3'b010}) begin errors++; $display("FAIL pre_reset got %h want %h", snap(), {1'b1, 10'd100, 12'd3, 3'b010}); end
    repeat (30) @(negedge clk);
    reset = 1'b1;
    cmd.cmd_valid = 1'b1; cmd.cmd_target = PW'(7); cmd.cmd_step = '0;
    @(negedge clk);
    checks++; if (snap() !== {1'b1, 10'd0, 12'd2, 3'b000}) begin errors++; $display("FAIL mid_reset got %h want %h", snap(), {1'b1, 10'd0, 12'd2, 3'b000}); end
    repeat (3) @(negedge clk);
    checks++; if (snap() !== {1'b1, 10'd0, 12'd2, 3'b000}) begin errors++; $display("FAIL reset_hold got %h want %h", snap(), {1'b1, 10'd0, 12'd2, 3'b000}); end
    cmd.cmd_valid = 1'b0;
    cfg_t_lsb = TW'(2);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (snap() !== {1'b0, 10'd0, 12'd2, 3'b100}) begin errors++; $display("FAIL post_reset got %h want %h", snap(), {1'b0, 10'd0, 12'd2, 3'b100}); end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down_and_jump();
    test_tlsb_change();
    test_enable_drop();
    test_reset_mid_ramp();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/pwm_ramp_scheduler.md
Name: pwm_ramp_scheduler

Overview:
Controller that sequences the pwm_generator datapath. It generates the period sync pulse and owns the generator's pwm_value and t_lsb inputs. It ramps the duty value toward a commanded target, one step per PWM period, and changes outputs only at period boundaries so the generator never sees a mid-period update. It sits between the register/command interface and pwm_generator.

Parameters:
PWM_WIDTH, 10, duty resolution; one period = 2^PWM_WIDTH slots.
TLSB_WIDTH, 12, width of the slot-length (clocks per LSB) value.
DEFAULT_TLSB, 2, t_lsb value driven after reset.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
enable  input  1  run control; low forces the OFF state
cfg_t_lsb  input  TLSB_WIDTH  requested clocks per slot; sampled at period end
cmd_valid  input  1  new ramp command present
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
cmd_target  input  PWM_WIDTH  ramp target duty
cmd_step  input  PWM_WIDTH  per-period step; 0 = jump directly to target
sync_signal  output  1  to generator; held high in OFF, 1-cycle pulse per period otherwise
pwm_value  output  PWM_WIDTH  to generator duty input
t_lsb  output  TLSB_WIDTH  to generator slot-length input
busy  output  1  high in RAMP
ramp_done  output  1  1-cycle pulse when target reached

Behaviour:
- All outputs registered. Reset values: sync_signal=1, pwm_value=0, t_lsb=DEFAULT_TLSB, cmd_ready=0, busy=0, ramp_done=0, all counters=0, state=OFF.
- Effective slot length: tl_eff = (t_lsb==0) ? 1 : t_lsb.
- Prescaler lsb_cnt counts 0..tl_eff-1. tick = (lsb_cnt==tl_eff-1). slot_cnt increments on tick and wraps 2^PWM_WIDTH-1 -> 0.
- period_end = tick && slot_cnt==2^PWM_WIDTH-1. Period length = 2^PWM_WIDTH * tl_eff clocks.
- On the clock edge where period_end is true: sync_signal <= 1 for exactly one cycle; t_lsb <= cfg_t_lsb; the RAMP update is applied. pwm_value and t_lsb never change at any other time, except on entry to OFF.
- States:
  - OFF: sync_signal=1, pwm_value=0, counters cleared, cmd_ready=0. enable=1 -> IDLE on the next edge. sync drops to 0 and counting starts on that edge, with lsb_cnt=0 in the first IDLE cycle.
  - IDLE: cmd_ready=1. On cmd_valid && cmd_ready: latch target/step, cmd_ready=0, busy=1, go to RAMP. Counters keep running; no period restart.
  - RAMP: at each period_end:
    - if step==0 or |target-pwm_value| <= step, pwm_value <= target, ramp_done pulses on the same edge as the sync pulse, -> IDLE;
    - otherwise pwm_value moves by step toward target.
    - Arithmetic is unsigned; direction comes from comparison; never overshoots, never wraps.
    - A target equal to the current value completes at the next period_end with ramp_done.
- enable=0 in any state -> OFF on the next edge, from IDLE or RAMP alike. In-flight ramp discarded, no ramp_done, pwm_value=0, t_lsb retains its value.
- cmd_valid while cmd_ready=0 is ignored; the requester holds it until accepted.
- Command acceptance coinciding with period_end in IDLE: the ramp starts counting from the following period; the first step is applied at the next period_end.
- reset overrides everything in the cycle it is asserted, including mid-ramp.

Test Plan:
- Reset 5 cycles, cfg_t_lsb=2, enable=1 -> sync_signal 1 through reset/OFF, 0 in the first IDLE cycle. First 1-cycle sync pulse 2048 clocks later, then every 2048 clocks. pwm_value=0, t_lsb=2.
- From 0, command target=500 step=100 accepted in IDLE -> pwm_value 100,200,300,400,500 on five successive sync pulses. ramp_done pulses with the 500 update. busy is high from the cycle after accept until that edge. cmd_ready returns high.
- From 500, target=130 step=200 -> pwm_value 300 then 130, no undershoot, done after 2 periods. Then target=1023 step=0 -> jump to 1023 at the next sync pulse.
- cfg_t_lsb changed 2->0 mid-period -> the current period still completes at 2048 clocks, t_lsb output becomes 0, and the next period is 1024 clocks (tl_eff=1).
- enable dropped mid-ramp at pwm_value=200 -> next cycle sync_signal=1, pwm_value=0, busy=0, no ramp_done. Re-enable -> IDLE, period restarts from count 0.
- reset asserted mid-ramp -> all outputs return to reset values on the next edge; cmd_valid held during reset is not accepted.
